// File: rtl/seg7_scan_reader_pkg.sv
// seg7_scan_reader_pkg: segment patterns (seg[0]=a ... seg[6]=g, active low), FSM states
package seg7_scan_reader_pkg;
  typedef logic [0:6] seg_t;
  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_e;
  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_TAB [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/seg7_scan_reader_to_hex.sv
// seg7_scan_reader_to_hex: combinational segment pattern -> {hit, blank, nibble} lookup
module seg7_scan_reader_to_hex
  import seg7_scan_reader_pkg::*;
(
  input  logic [0:6] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] nibble
);
  always_comb begin
    hit = 1'b0;
    nibble = '0;
    for (int k = 0; k < 16; k++) begin
      if (seg == SEG_TAB[k]) begin
        hit = 1'b1;
        nibble = 4'(k);
      end
    end
  end
  assign blank = seg == SEG_BLANK;
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: rebuilds hex digits from a multiplexed active-low 7-segment bus once each dwell settles
module seg7_scan_reader
  import seg7_scan_reader_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:6]            seg,
  input  logic [N_DIGITS-1:0]   an,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   valid,
  output logic                  err,
  output logic                  frame_done,
  output logic                  lost
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT);
  state_e state_q, state_d;
  seg_t seg_q;
  logic [N_DIGITS-1:0] an_q, sel, seen_q, seen_d, valid_q, valid_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d, fd_q, fd_d, lost_q, lost_d;
  logic one_hot, same, cap, hit, blank;
  logic [3:0] nibble;
  seg7_scan_reader_to_hex u_dec (.seg(seg), .hit(hit), .blank(blank), .nibble(nibble));
  assign sel = ~an;
  assign one_hot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign same = (seg == seg_q) && (an == an_q);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cap = 1'b0;
    if (!one_hot) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == IDLE || !same) begin
      state_d = TRACK;
      cnt_d = CW'(1);
    end else if (state_q == TRACK) begin
      cnt_d = cnt_q + 1'b1;
      cap = cnt_d == STABLE_C;
      state_d = cap ? HELD : TRACK;
    end
  end
  // a capture always wins over the timeout, even on the expiry edge
  always_comb begin
    digits_d = digits_q;
    valid_d = valid_q;
    seen_d = seen_q;
    err_d = 1'b0;
    fd_d = 1'b0;
    lost_d = lost_q;
    tmo_d = (tmo_q == TMO_C) ? tmo_q : tmo_q + 1'b1;
    if (cap) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (sel[i]) begin
          digits_d[4*i +: 4] = hit ? nibble : digits_q[4*i +: 4];
          valid_d[i] = hit;
        end
      end
      err_d = !hit && !blank;
      seen_d = seen_q | sel;
      fd_d = &seen_d;
      seen_d = fd_d ? '0 : seen_d;
      tmo_d = '0;
      lost_d = 1'b0;
    end else if (tmo_d == TMO_C) begin
      lost_d = 1'b1;
      valid_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seg_q <= SEG_BLANK;
      an_q <= '1;
      cnt_q <= '0;
      tmo_q <= '0;
      digits_q <= '0;
      valid_q <= '0;
      seen_q <= '0;
      err_q <= 1'b0;
      fd_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q <= seg;
      an_q <= an;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      digits_q <= digits_d;
      valid_q <= valid_d;
      seen_q <= seen_d;
      err_q <= err_d;
      fd_q <= fd_d;
      lost_q <= lost_d;
    end
  end
  assign digits = digits_q;
  assign valid = valid_q;
  assign err = err_q;
  assign frame_done = fd_q;
  assign lost = lost_q;
endmodule
